text_console_ctrl: RTL and testbench
====================================

Name: text_console_ctrl

Overview:
- Command sequencer for the character-processor write port (new_char / waddr / text_en) into the 80x30 text buffer.
- Accepts CPU commands over a valid/ready handshake:
  - put character at a hardware cursor, with auto-advance;
  - clear screen, filling every cell with one glyph;
  - set cursor position.
- Owns the cursor and converts it to a linear cell address. The CPU therefore never computes waddr itself.

Parameters:
- COLS, 80, characters per row (640 px / 8).
- ROWS, 30, character rows (480 px / 16).
- ADDR_W, 12, text-buffer address width; must satisfy COLS*ROWS <= 2**ADDR_W.
- CHAR_W, 4, glyph code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  00 PUTC, 01 CLEAR, 10 SETPOS, 11 reserved.
- cmd_data  in  12  PUTC/CLEAR: [3:0] glyph; SETPOS: [11:7] row, [6:0] col.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- new_char  out  CHAR_W  glyph to text buffer.
- waddr  out  ADDR_W  cell address, row*COLS+col.
- text_en  out  1  text-buffer write strobe.
- busy  out  1  CLEAR in progress.
- cursor_row  out  5  current cursor row.
- cursor_col  out  7  current cursor column.

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=0, text_en=0, new_char=0, waddr=0, busy=0, cursor_row=0, cursor_col=0, FSM=IDLE.
- cmd_ready is 1 from the first cycle after rst deasserts.
- FSM states:
  - IDLE: cmd_ready=1.
  - CLEAR: cmd_ready=0, busy=1.
- Cursor state is held as row, col and a linear address cur_addr. They advance together, so no multiplier is needed on the PUTC path.
- PUTC accept in IDLE:
  - The next cycle has text_en=1, waddr=cur_addr, new_char=cmd_data[3:0], for exactly one cycle unless another PUTC follows.
  - The cursor advances in the same cycle as the write: col+1.
  - At col==COLS-1: col=0, row+1.
  - At row==ROWS-1, col==COLS-1: wrap to (0,0), cur_addr=0.
  - FSM stays in IDLE. Throughput is 1 PUTC per cycle, and back-to-back PUTCs produce contiguous text_en.
- CLEAR accept:
  - Latch the fill glyph, enter CLEAR, set the internal counter to 0.
  - Each cycle emits text_en=1, waddr=counter, new_char=fill, for counter 0..COLS*ROWS-1 (2400 cycles).
  - The cycle after the last write: text_en=0, busy=0, cursor=(0,0), back to IDLE with cmd_ready=1.
  - Commands presented during CLEAR are not accepted; the CPU holds cmd_valid.
- SETPOS accept:
  - If row<ROWS and col<COLS, the cursor is loaded next cycle and cur_addr=row*COLS+col (constant multiply).
  - Otherwise the command is consumed and the cursor is unchanged.
  - No write is issued.
- Reserved op: consumed, no effect.
- Reset mid-CLEAR aborts the clear immediately at the next edge. All outputs take their reset values; partially cleared cells stay as written.
- Text_buffer/VRAM timing is unaffected. Writes are independent of dot/scanline counters; the text buffer has a dedicated write port.

Optional Feature:
- Macro TEXT_NEWLINE_EN.
- Defined:
  - PUTC with glyph 4'hF issues no write.
  - The cursor moves to col=0, row+1, wrapping row ROWS-1 to 0.
  - cur_addr is updated accordingly (cur_addr - col + COLS, or 0 on wrap).
  - cmd_ready timing is unchanged.
- Not defined: 4'hF is an ordinary glyph and is written like any other.

Decomposition:
- Package text_pkg:
  - typedef for the cmd_op enum (OP_PUTC, OP_CLEAR, OP_SETPOS, OP_RSVD);
  - FSM state enum;
  - constants TXT_COLS, TXT_ROWS, TXT_CELLS = TXT_COLS*TXT_ROWS.
- One sub-module, text_cursor: row/col/cur_addr registers with inc, newline, load and zero controls. The top holds the FSM, clear counter and output registers.

Test Plan:
- Reset then PUTC 'A'=4'h3 → next cycle text_en=1, waddr=0, new_char=3; cursor=(0,1).
- SETPOS row=2,col=79 then PUTC 4'h5 → waddr=239; cursor=(3,0).
- SETPOS (29,79) then PUTC 4'h1 → waddr=2399; cursor wraps to (0,0). SETPOS row=30 → cursor unchanged.
- CLEAR fill 4'h0 → busy=1 and cmd_ready=0 for 2400 cycles with text_en=1 and waddr 0..2399 sequential. A PUTC held during the clear is accepted only after busy falls and writes waddr=0.
- rst pulsed at clear cycle 1000 → next cycle text_en=0, busy=0, cursor=(0,0). The cycle after rst deasserts, cmd_ready=1.
- With TEXT_NEWLINE_EN: SETPOS (4,10) then PUTC 4'hF → no text_en; cursor=(5,0); a following PUTC writes waddr=400.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and geometry for the text console command sequencer.
// Defines command opcodes, FSM states and the 80x30 cell constants.
package text_pkg;

   localparam int TXT_COLS   = 80;
   localparam int TXT_ROWS   = 30;
   localparam int TXT_CELLS  = TXT_COLS * TXT_ROWS;
   localparam int TXT_ADDR_W = 12;
   localparam int TXT_CHAR_W = 4;

   typedef enum logic [1:0] {
      OP_PUTC   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_SETPOS = 2'b10,
      OP_RSVD   = 2'b11
   } cmd_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/text_console_ctrl_if.sv
// CPU command channel: valid/ready handshake with opcode and payload.
// master = CPU side (drives valid/op/data), slave = sequencer side (drives ready).
interface text_console_ctrl_if;
   import text_pkg::*;

   logic        cmd_valid;
   cmd_op_e     cmd_op;
   logic [11:0] cmd_data;
   logic        cmd_ready;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/text_cursor.sv
// Hardware cursor: row, col and the matching linear cell address.
// Ports: clk, rst, inc/nl/load/zero controls, ld_row/ld_col, row/col/addr out.
module text_cursor
   import text_pkg::*;
#(
   parameter int COLS   = TXT_COLS,
   parameter int ROWS   = TXT_ROWS,
   parameter int ADDR_W = TXT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              nl,
   input  logic              load,
   input  logic              zero,
   input  logic [4:0]        ld_row,
   input  logic [6:0]        ld_col,
   output logic [4:0]        row,
   output logic [6:0]        col,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [4:0]        ROW_MAX = 5'(ROWS - 1);
   localparam logic [6:0]        COL_MAX = 7'(COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);

   logic last_row;
   assign last_row = (row == ROW_MAX);

   // addr tracks row*COLS+col incrementally; only load multiplies
   always_ff @(posedge clk) begin
      if (rst || zero) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (load) begin
         row  <= ld_row;
         col  <= ld_col;
         addr <= ADDR_W'(ld_row) * COLS_A + ADDR_W'(ld_col);
      end else if (nl) begin
         col <= '0;
         if (last_row) begin
            row  <= '0;
            addr <= '0;
         end else begin
            row  <= row + 1'b1;
            addr <= addr - ADDR_W'(col) + COLS_A;
         end
      end else if (inc) begin
         if (col == COL_MAX) begin
            col <= '0;
            if (last_row) begin
               row  <= '0;
               addr <= '0;
            end else begin
               row  <= row + 1'b1;
               addr <= addr + 1'b1;
            end
         end else begin
            col  <= col + 1'b1;
            addr <= addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Command sequencer driving the text-buffer write port (PUTC/CLEAR/SETPOS).
// Ports: clk, rst, cmd (slave if), new_char, waddr, text_en, busy, cursor_row/col.
// Option: define TEXT_NEWLINE_EN to make glyph 4'hF a newline instead of a write.
module text_console_ctrl
   import text_pkg::*;
#(
   parameter int COLS   = TXT_COLS,
   parameter int ROWS   = TXT_ROWS,
   parameter int ADDR_W = TXT_ADDR_W,
   parameter int CHAR_W = TXT_CHAR_W
) (
   input  logic                clk,
   input  logic                rst,
   text_console_ctrl_if.slave  cmd,
   output logic [CHAR_W-1:0]   new_char,
   output logic [ADDR_W-1:0]   waddr,
   output logic                text_en,
   output logic                busy,
   output logic [4:0]          cursor_row,
   output logic [6:0]          cursor_col
);

   localparam logic [ADDR_W-1:0] CELLS   = ADDR_W'(COLS * ROWS);
   localparam logic [4:0]        ROW_LIM = 5'(ROWS);
   localparam logic [6:0]        COL_LIM = 7'(COLS);

   state_e              state_q, state_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                en_q, en_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [CHAR_W-1:0]   char_q, char_d;
   logic [ADDR_W-1:0]   cur_addr;
   logic                acc, inc, nl, load, zero, is_nl;
   logic [CHAR_W-1:0]   glyph;
   logic [4:0]          set_row;
   logic [6:0]          set_col;

   // ready_q is only ever high in IDLE
   assign acc     = cmd.cmd_valid & ready_q;
   assign glyph   = cmd.cmd_data[CHAR_W-1:0];
   assign set_row = cmd.cmd_data[11:7];
   assign set_col = cmd.cmd_data[6:0];

`ifdef TEXT_NEWLINE_EN
   assign is_nl = (glyph == '1);
`else
   assign is_nl = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // cnt_q holds the next address to write; the first cell is
   // written on the accept edge so busy and text_en line up
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      en_d    = 1'b0;
      waddr_d = waddr_q;
      char_d  = char_q;
      cnt_d   = cnt_q;
      inc     = 1'b0;
      nl      = 1'b0;
      load    = 1'b0;
      zero    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (acc) begin
               unique case (cmd.cmd_op)
                  OP_PUTC: begin
                     if (is_nl) begin
                        nl = 1'b1;
                     end else begin
                        en_d    = 1'b1;
                        waddr_d = cur_addr;
                        char_d  = glyph;
                        inc     = 1'b1;
                     end
                  end
                  OP_CLEAR: begin
                     state_d = ST_CLEAR;
                     ready_d = 1'b0;
                     busy_d  = 1'b1;
                     en_d    = 1'b1;
                     waddr_d = '0;
                     char_d  = glyph;
                     cnt_d   = ADDR_W'(1);
                  end
                  OP_SETPOS: begin
                     load = (set_row < ROW_LIM) && (set_col < COL_LIM);
                  end
                  default: ;
               endcase
            end
         end
         ST_CLEAR: begin
            // char_q keeps the latched fill glyph throughout
            if (cnt_q == CELLS) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               zero    = 1'b1;
            end else begin
               en_d    = 1'b1;
               waddr_d = cnt_q;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
         waddr_q <= '0;
         char_q  <= '0;
         cnt_q   <= '0;
      end else begin
         ready_q <= ready_d;
         busy_q  <= busy_d;
         en_q    <= en_d;
         waddr_q <= waddr_d;
         char_q  <= char_d;
         cnt_q   <= cnt_d;
      end
   end

   text_cursor #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_cursor (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc),
      .nl     (nl),
      .load   (load),
      .zero   (zero),
      .ld_row (set_row),
      .ld_col (set_col),
      .row    (cursor_row),
      .col    (cursor_col),
      .addr   (cur_addr)
   );

   assign cmd.cmd_ready = ready_q;
   assign text_en       = en_q;
   assign waddr         = waddr_q;
   assign new_char      = char_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: directed cases plus random
// commands against a row/col reference model.
module tb_text_console_ctrl;
   import text_pkg::*;

`ifdef TEXT_NEWLINE_EN
   localparam bit NL_EN = 1'b1;
`else
   localparam bit NL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  new_char;
   logic [11:0] waddr;
   logic        text_en;
   logic        busy;
   logic [4:0]  cursor_row;
   logic [6:0]  cursor_col;

   text_console_ctrl_if cif ();

   text_console_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cif),
      .new_char   (new_char),
      .waddr      (waddr),
      .text_en    (text_en),
      .busy       (busy),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // reference model: cursor as (row,col); address derived by multiply
   int m_row, m_col, m_waddr, m_char, m_fill, m_clr;
   bit m_en, m_ready, m_busy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] pos(input int r, input int c);
      logic [4:0] rr;
      logic [6:0] cc;
      rr = 5'(r);
      cc = 7'(c);
      return {rr, cc};
   endfunction

   task automatic model(input bit v, input cmd_op_e op,
                        input logic [11:0] d);
      bit acc;
      acc  = v && m_ready;
      m_en = 1'b0;
      if (rst) begin
         m_row = 0; m_col = 0; m_waddr = 0; m_char = 0;
         m_ready = 0; m_busy = 0; m_clr = -1;
      end else if (m_clr >= 0) begin
         if (m_clr == TXT_CELLS) begin
            m_clr = -1; m_ready = 1; m_busy = 0;
            m_row = 0; m_col = 0;
         end else begin
            m_en = 1; m_waddr = m_clr; m_char = m_fill;
            m_clr++;
         end
      end else begin
         m_ready = 1;
         if (acc) begin
            case (op)
               OP_PUTC: begin
                  if (NL_EN && d[3:0] == 4'hF) begin
                     m_col = 0;
                     m_row = (m_row + 1) % TXT_ROWS;
                  end else begin
                     m_en    = 1;
                     m_waddr = m_row * TXT_COLS + m_col;
                     m_char  = int'(d[3:0]);
                     m_col++;
                     if (m_col == TXT_COLS) begin
                        m_col = 0;
                        m_row = (m_row + 1) % TXT_ROWS;
                     end
                  end
               end
               OP_CLEAR: begin
                  m_fill = int'(d[3:0]);
                  m_en = 1; m_waddr = 0; m_char = m_fill;
                  m_clr = 1; m_busy = 1; m_ready = 0;
               end
               OP_SETPOS: begin
                  if (int'(d[11:7]) < TXT_ROWS && int'(d[6:0]) < TXT_COLS) begin
                     m_row = int'(d[11:7]);
                     m_col = int'(d[6:0]);
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   // drive at negedge, model at posedge, sample at next negedge
   task automatic tick(input bit v, input cmd_op_e op,
                       input logic [11:0] d);
      cif.cmd_valid = v;
      cif.cmd_op    = op;
      cif.cmd_data  = d;
      @(posedge clk);
      model(v, op, d);
      @(negedge clk);
      chk("en", text_en, m_en);
      chk("ready", cif.cmd_ready, m_ready);
      chk("busy", busy, m_busy);
      chk("row", cursor_row, m_row);
      chk("col", cursor_col, m_col);
      if (m_en) begin
         chk("waddr", waddr, m_waddr);
         chk("char", new_char, m_char);
      end
   endtask

   task automatic idle();
      tick(1'b0, OP_PUTC, 12'h0);
   endtask

   initial begin
      int n_busy;
      int r;
      bit v;
      cmd_op_e op;
      cif.cmd_valid = 1'b0;
      cif.cmd_op    = OP_PUTC;
      cif.cmd_data  = '0;
      m_clr = -1; m_fill = 0;
      @(negedge clk);

      rst = 1'b1;
      repeat (3) idle();
      chk("rst_ready", cif.cmd_ready, 0);
      chk("rst_waddr", waddr, 0);
      rst = 1'b0;
      idle();
      chk("ready_after_rst", cif.cmd_ready, 1);

      tick(1'b1, OP_PUTC, 12'h003);
      chk("p1_en", text_en, 1);
      chk("p1_waddr", waddr, 0);
      chk("p1_char", new_char, 3);
      chk("p1_col", cursor_col, 1);
      idle();
      chk("p1_en_drop", text_en, 0);

      tick(1'b1, OP_SETPOS, pos(2, 79));
      tick(1'b1, OP_PUTC, 12'h005);
      chk("p2_waddr", waddr, 239);
      chk("p2_row", cursor_row, 3);
      chk("p2_col", cursor_col, 0);

      tick(1'b1, OP_SETPOS, pos(29, 79));
      tick(1'b1, OP_PUTC, 12'h001);
      chk("p3_waddr", waddr, 2399);
      chk("p3_row", cursor_row, 0);
      chk("p3_col", cursor_col, 0);
      tick(1'b1, OP_SETPOS, pos(30, 5));
      chk("bad_row", cursor_row, 0);
      tick(1'b1, OP_SETPOS, pos(3, 80));
      chk("bad_col", cursor_col, 0);
      tick(1'b1, OP_SETPOS, pos(1, 2));
      tick(1'b1, OP_PUTC, 12'h00A);
      tick(1'b1, OP_PUTC, 12'h00B);
      chk("b2b_en", text_en, 1);
      chk("b2b_waddr", waddr, 83);

      tick(1'b1, OP_CLEAR, 12'h000);
      n_busy = busy ? 1 : 0;
      for (int i = 0; i < 2500; i++) begin
         tick(1'b1, OP_PUTC, 12'h007);
         if (!busy) break;
         n_busy++;
      end
      chk("clr_cycles", n_busy, 2400);
      chk("clr_done_en", text_en, 0);
      chk("clr_done_ready", cif.cmd_ready, 1);
      tick(1'b1, OP_PUTC, 12'h007);
      chk("held_waddr", waddr, 0);
      chk("held_en", text_en, 1);

      tick(1'b1, OP_SETPOS, pos(7, 7));
      tick(1'b1, OP_CLEAR, 12'h00A);
      repeat (999) idle();
      chk("mid_waddr", waddr, 999);
      rst = 1'b1;
      idle();
      chk("abort_en", text_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_row", cursor_row, 0);
      rst = 1'b0;
      idle();
      chk("abort_ready", cif.cmd_ready, 1);

      tick(1'b1, OP_SETPOS, pos(4, 10));
      tick(1'b1, OP_PUTC, 12'h00F);
`ifdef TEXT_NEWLINE_EN
      chk("nl_en", text_en, 0);
      chk("nl_row", cursor_row, 5);
      chk("nl_col", cursor_col, 0);
      tick(1'b1, OP_PUTC, 12'h002);
      chk("nl_waddr", waddr, 400);
`else
      chk("f_en", text_en, 1);
      chk("f_waddr", waddr, 330);
      chk("f_char", new_char, 15);
`endif
      tick(1'b1, OP_RSVD, 12'hFFF);
      chk("rsvd_en", text_en, 0);

      for (int i = 0; i < 6000; i++) begin
         r = $urandom_range(0, 63);
         v = ($urandom_range(0, 3) != 0);
         if (r == 0)       op = OP_CLEAR;
         else if (r < 4)   op = OP_RSVD;
         else if (r < 16)  op = OP_SETPOS;
         else              op = OP_PUTC;
         tick(v, op, 12'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
